// File: rtl/mdu_ctrl_if.sv
// EX-stage <-> multiply/divide sequencer handshake bundle.
// master = EX pipeline side, slave = mdu_ctrl.
interface mdu_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             op_valid;
    logic [1:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             ex_stall;
    logic             flush;
    logic             stall_req;
    logic             res_valid;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;

    modport master (
        output op_valid, op, src_a, src_b, ex_stall, flush,
        input  stall_req, res_valid, hi, lo, busy
    );

    modport slave (
        input  op_valid, op, src_a, src_b, ex_stall, flush,
        output stall_req, res_valid, hi, lo, busy
    );
endinterface

// File: rtl/mdu_ctrl.sv
// MULT/MULTU/DIV/DIVU sequencer: fixed-latency multiply, 1-bit/cycle restoring divide.
// Optional macro DIV_ZERO_FAST_EN: divide by zero completes in the accept cycle.
module mdu_ctrl #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 2
) (
    input  logic       clk,
    input  logic       resetn,
    mdu_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [5:0] MUL_LAST = 6'((MUL_LAT > 1) ? MUL_LAT - 2 : 0);
    localparam logic [5:0] DIV_LAST = 6'(WIDTH - 1);
    localparam logic [5:0] CNT_MAX  = 6'(WIDTH);

    state_t           state_q, state_d;
    logic [5:0]       cnt_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             signed_q;
    logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
    logic [WIDTH-1:0] hi_q, lo_q, hi_d, lo_d;
    logic             accept;

    // Multiplier operands come straight from EX when finishing in the accept cycle.
    logic             mul_signed;
    logic [WIDTH-1:0] mul_a, mul_b;
    logic [2*WIDTH-1:0] ext_a, ext_b, product;

    always_comb begin
        mul_signed = (state_q == IDLE) ? ~bus.op[0] : signed_q;
        mul_a      = (state_q == IDLE) ? bus.src_a : a_q;
        mul_b      = (state_q == IDLE) ? bus.src_b : b_q;
        ext_a      = {{WIDTH{mul_signed & mul_a[WIDTH-1]}}, mul_a};
        ext_b      = {{WIDTH{mul_signed & mul_b[WIDTH-1]}}, mul_b};
        product    = ext_a * ext_b;
    end

    logic             in_signed;
    logic [WIDTH-1:0] abs_a, abs_b;

    always_comb begin
        in_signed = ~bus.op[0];
        abs_a     = (in_signed && bus.src_a[WIDTH-1]) ? -bus.src_a : bus.src_a;
        abs_b     = (in_signed && bus.src_b[WIDTH-1]) ? -bus.src_b : bus.src_b;
    end

    // One restoring step: shift in next dividend bit, subtract if it fits.
    logic [WIDTH:0]   rem_shift, diff;
    logic             q_bit;
    logic [WIDTH-1:0] rem_next, quo_next, hi_fix, lo_fix;

    always_comb begin
        rem_shift = {rem_q, quo_q[WIDTH-1]};
        diff      = rem_shift - {1'b0, dvs_q};
        q_bit     = ~diff[WIDTH];
        rem_next  = q_bit ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        quo_next  = {quo_q[WIDTH-2:0], q_bit};
        lo_fix    = (signed_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -quo_next : quo_next;
        hi_fix    = (signed_q && a_q[WIDTH-1]) ? -rem_next : rem_next;
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.op_valid && !bus.flush) begin
                    accept = 1'b1;
                    if (bus.op[1]) begin
`ifdef DIV_ZERO_FAST_EN
                        if (bus.src_b == '0) begin
                            state_d = DONE;
                            hi_d    = bus.src_a;
                            lo_d    = '1;
                        end else begin
                            state_d = DIV;
                        end
`else
                        state_d = DIV;
`endif
                    end else if (MUL_LAT == 1) begin
                        state_d      = DONE;
                        {hi_d, lo_d} = product;
                    end else begin
                        state_d = MUL;
                    end
                end
            end
            MUL: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else if (cnt_q == MUL_LAST) begin
                    state_d      = DONE;
                    {hi_d, lo_d} = product;
                end
            end
            DIV: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else if (cnt_q == DIV_LAST) begin
                    state_d = DONE;
                    if (b_q == '0) begin
                        hi_d = a_q;
                        lo_d = '1;
                    end else begin
                        hi_d = hi_fix;
                        lo_d = lo_fix;
                    end
                end
            end
            DONE: begin
                if (bus.flush || !bus.ex_stall) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            signed_q <= 1'b0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
        end else if (accept) begin
            cnt_q    <= '0;
            a_q      <= bus.src_a;
            b_q      <= bus.src_b;
            signed_q <= in_signed;
            rem_q    <= '0;
            quo_q    <= abs_a;
            dvs_q    <= abs_b;
        end else if (state_q == DIV) begin
            rem_q <= rem_next;
            quo_q <= quo_next;
            cnt_q <= (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 6'd1;
        end else if (state_q == MUL) begin
            cnt_q <= (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 6'd1;
        end
    end

    // Gated by resetn so the pipeline is never stalled while the block is held in reset.
    assign bus.stall_req = resetn & bus.op_valid & ~bus.flush & (state_q != DONE);
    assign bus.res_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl with a result scoreboard.
// Honours DIV_ZERO_FAST_EN for the expected divide-by-zero latency.
module tb_mdu_ctrl;
    localparam int W = 32;

`ifdef DIV_ZERO_FAST_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 33;
`endif

    logic clk = 1'b0;
    logic resetn;
    int   total = 0;
    int   bad   = 0;
    logic [63:0] sb_q[$];

    always #5 clk = ~clk;

    mdu_ctrl_if #(.WIDTH(W)) bus ();

    mdu_ctrl #(.WIDTH(W), .MUL_LAT(2)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint p;
        int     q, r;
        if (op == 2'd0) begin
            p = longint'($signed(a)) * longint'($signed(b));
            return p;
        end
        if (op == 2'd1) return {32'b0, a} * {32'b0, b};
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (op == 2'd2) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
            return {r, q};
        end
        return {a % b, a / b};
    endfunction

    // Presents one op in IDLE, waits for DONE, optionally holds it with ex_stall.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int exp_lat,
                          input int hold);
        int          n;
        logic [63:0] want;
        sb_q.push_back(exp);
        bus.op_valid = 1'b1;
        bus.op       = op;
        bus.src_a    = a;
        bus.src_b    = b;
        #1;
        check({tag, "_accept_stall"}, 64'(bus.stall_req), 64'd1);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.res_valid && n < 100);
        check({tag, "_latency"}, 64'(n), 64'(exp_lat));
        want = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hx;
        check({tag, "_hi"}, 64'(bus.hi), 64'(want[63:32]));
        check({tag, "_lo"}, 64'(bus.lo), 64'(want[31:0]));
        check({tag, "_done_stall"}, 64'(bus.stall_req), 64'd0);
        if (hold > 0) begin
            bus.ex_stall = 1'b1;
            repeat (hold) begin
                @(posedge clk);
                #1;
                check({tag, "_held_valid"}, 64'(bus.res_valid), 64'd1);
                check({tag, "_held_hilo"}, {bus.hi, bus.lo}, want);
            end
            bus.ex_stall = 1'b0;
        end
        bus.op_valid = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_after_valid"}, 64'(bus.res_valid), 64'd0);
        check({tag, "_after_busy"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [1:0]  rop;
        int          seen;

        resetn       = 1'b0;
        bus.op_valid = 1'b1;
        bus.op       = 2'd0;
        bus.src_a    = 32'd1;
        bus.src_b    = 32'd1;
        bus.ex_stall = 1'b0;
        bus.flush    = 1'b0;
        #3;
        check("reset_stall", 64'(bus.stall_req), 64'd0);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_valid", 64'(bus.res_valid), 64'd0);
        check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
        #9;
        bus.op_valid = 1'b0;
        resetn       = 1'b1;
        @(posedge clk);
        #1;

        // Multiply and divide results with their latencies.
        run_op("mult_neg", 2'd0, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, 2, 0);
        run_op("mult_min", 2'd0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 2, 0);
        run_op("divu_100_7", 2'd3, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 0);
        run_op("div_m7_2", 2'd2, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33, 0);
        run_op("div_7_m2", 2'd2, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 33, 0);

        // Divide by zero forces lo to all ones and hi to the raw dividend.
        run_op("div_5_0", 2'd2, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, ZLAT, 0);
        run_op("div_m8_0", 2'd2, 32'hFFFF_FFF8, 32'd0, {32'hFFFF_FFF8, 32'hFFFF_FFFF}, ZLAT, 0);
        run_op("divu_big_0", 2'd3, 32'hFFFF_0000, 32'd0, {32'hFFFF_0000, 32'hFFFF_FFFF}, ZLAT, 0);

        // Flush mid-divide.
        bus.op_valid = 1'b1;
        bus.op       = 2'd3;
        bus.src_a    = 32'd1000;
        bus.src_b    = 32'd7;
        @(posedge clk);
        #1;
        repeat (10) @(posedge clk);
        #1;
        check("flush_busy_before", 64'(bus.busy), 64'd1);
        bus.flush = 1'b1;
        #1;
        check("flush_stall_drop", 64'(bus.stall_req), 64'd0);
        @(posedge clk);
        #1;
        check("flush_idle", 64'(bus.busy), 64'd0);
        bus.flush    = 1'b0;
        bus.op_valid = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.res_valid) seen++;
        end
        check("flush_no_valid", 64'(seen), 64'd0);

        // Flush together with op_valid in IDLE.
        bus.op_valid = 1'b1;
        bus.flush    = 1'b1;
        #1;
        check("flush_idle_stall", 64'(bus.stall_req), 64'd0);
        @(posedge clk);
        #1;
        check("flush_idle_busy", 64'(bus.busy), 64'd0);
        bus.op_valid = 1'b0;
        bus.flush    = 1'b0;
        @(posedge clk);
        #1;

        // ex_stall at DONE, then a back-to-back MULTU.
        run_op("multu_hold", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 2, 3);
        run_op("multu_b2b", 2'd1, 32'h1234_5678, 32'h9ABC_DEF0,
               model(2'd1, 32'h1234_5678, 32'h9ABC_DEF0), 2, 0);

        // Mixed random operations against the reference model.
        for (int i = 0; i < 6; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            if (rb == 0) rb = 32'd3;
            if (rop == 2'd2 && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd1;
            run_op($sformatf("rand%0d", i), rop, ra, rb, model(rop, ra, rb),
                   rop[1] ? 33 : 2, 0);
        end

        run_op("mult_pre_reset", 2'd0, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, 2, 0);

        // Asynchronous reset mid-divide.
        bus.op_valid = 1'b1;
        bus.op       = 2'd3;
        bus.src_a    = 32'd1000;
        bus.src_b    = 32'd3;
        repeat (6) @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("arst_stall", 64'(bus.stall_req), 64'd0);
        check("arst_busy", 64'(bus.busy), 64'd0);
        check("arst_valid", 64'(bus.res_valid), 64'd0);
        check("arst_hilo", {bus.hi, bus.lo}, 64'd0);
        bus.op_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        run_op("divu_9_3", 2'd3, 32'd9, 32'd3, {32'd0, 32'd3}, 33, 0);

        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
